// File: rtl/game_result_pkg.sv
// Shared encodings for the game result controller: winState codes,
// controller states and small saturating helpers.
package game_result_pkg;

  // winState codes from the king-state evaluator (4..7 read as continue)
  typedef enum logic [1:0] {
    CONTINUE = 2'd0,
    WHITEWIN = 2'd1,
    BLACKWIN = 2'd2,
    DRAW     = 2'd3
  } result_e;

  // Controller states; SETTLE is the reset state
  typedef enum logic [2:0] {
    SETTLE   = 3'd0,
    PLAY     = 3'd1,
    CHECKED  = 3'd2,
    HOLD     = 3'd3,
    WAIT_NEW = 3'd4,
    CLEAR    = 3'd5
  } game_state_e;

  localparam int SCORE_W    = 4;
  localparam int MOVE_CNT_W = 16;

  // True for a real game result (1..3); 0 and 4..7 mean keep playing
  function automatic logic isResult(input logic [2:0] ws);
    return (ws[2] == 1'b0) && (ws[1:0] != 2'b00);
  endfunction

  // Score increment that sticks at all-ones
  function automatic logic [SCORE_W-1:0] satInc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/game_result_ctrl_confirm.sv
// result_confirm: debounces winState. A value is only acted on after it
// has been sampled CONFIRM_CYCLES times in a row.
module result_confirm
  import game_result_pkg::*;
#(
  parameter int CONFIRM_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic [2:0] winState,
  output logic       confirmed,
  output logic       clear,
  output logic [1:0] resultCode
);

  localparam int CW = $clog2(CONFIRM_CYCLES + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(CONFIRM_CYCLES);

  logic [2:0]    sample;
  logic [CW-1:0] runCnt;
  logic          runDone;

  // Track the last sample and how many consecutive times it has been seen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample <= '0;
      runCnt <= '0;
    end else if (clr) begin
      sample <= winState;
      runCnt <= '0;
    end else begin
      sample <= winState;
      if (winState != sample)
        runCnt <= CW'(1);
      else if (runCnt != RUN_MAX)
        runCnt <= runCnt + 1'b1;
    end
  end

  assign runDone    = (runCnt == RUN_MAX);
  assign confirmed  = runDone && isResult(sample);
  assign clear      = runDone && !isResult(sample);
  assign resultCode = isResult(sample) ? sample[1:0] : 2'b00;

endmodule

// File: rtl/game_result_ctrl.sv
// game_result_ctrl: gates moves while in check, latches and shows the game
// result, keeps per-colour scores and sequences a new game.
module game_result_ctrl
  import game_result_pkg::*;
#(
  parameter int CONFIRM_CYCLES = 4,
  parameter int HOLD_CYCLES    = 100000000,
  parameter int BLINK_CYCLES   = 25000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   winState,
  input  logic         check,
  input  logic         allowMoveIn,
  input  logic         pieceIsKing,
  input  logic         moveCommit,
  input  logic         newGameBtn,
  output logic         allowMove,
  output logic         gameOver,
  output logic [1:0]   result,
  output logic         checkLed,
  output logic         resultBlink,
  output logic         boardReset,
  output logic [3:0]   whiteScore,
  output logic [3:0]   blackScore,
  output logic [3:0]   drawCount
);

  localparam int HW = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  game_state_e state, nextState;

  logic                  confirmed, settled;
  logic [1:0]            resultCode;
  logic                  newGameBtnD, newEdge;
  logic                  enterHold;
  logic [HW-1:0]         holdCnt;
  logic [BW-1:0]         blinkCnt;
  logic                  blinkQ;
  logic [1:0]            resultQ;
  logic [SCORE_W-1:0]    whiteQ, blackQ, drawQ;
  logic [MOVE_CNT_W-1:0] moveCnt;

  result_confirm #(.CONFIRM_CYCLES(CONFIRM_CYCLES)) uConfirm (
    .clk       (clk),
    .reset     (reset),
    .clr       (state == CLEAR),
    .winState  (winState),
    .confirmed (confirmed),
    .clear     (settled),
    .resultCode(resultCode)
  );

  // Button edge detect: remember last level of the debounced button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) newGameBtnD <= 1'b0;
    else       newGameBtnD <= newGameBtn;
  end

  assign newEdge = newGameBtn & ~newGameBtnD;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SETTLE;
    else       state <= nextState;
  end

  // Next state and move gating; a confirmed result beats a new-game press,
  // which beats a check change
  always_comb begin
    nextState = state;
    allowMove = 1'b0;
    unique case (state)
      SETTLE: begin
        if (settled) nextState = PLAY;
      end
      PLAY: begin
        allowMove = allowMoveIn;
        if (confirmed)    nextState = HOLD;
        else if (newEdge) nextState = CLEAR;
        else if (check)   nextState = CHECKED;
      end
      CHECKED: begin
        allowMove = allowMoveIn & pieceIsKing;
        if (confirmed)    nextState = HOLD;
        else if (newEdge) nextState = CLEAR;
        else if (!check)  nextState = PLAY;
      end
      HOLD: begin
        if (holdCnt == HOLD_LAST) nextState = WAIT_NEW;
      end
      WAIT_NEW: begin
        if (newEdge) nextState = CLEAR;
      end
      CLEAR: begin
        nextState = SETTLE;
      end
      default: nextState = SETTLE;
    endcase
  end

  assign enterHold = (nextState == HOLD) && (state != HOLD);

  // Latch the result on HOLD entry; drop it as the new game starts
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   resultQ <= 2'b00;
    else if (enterHold)          resultQ <= resultCode;
    else if (nextState == CLEAR) resultQ <= 2'b00;
  end

  // Scores bump once per game on HOLD entry and only reset clears them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      whiteQ <= '0;
      blackQ <= '0;
      drawQ  <= '0;
    end else if (enterHold) begin
      case (resultCode)
        WHITEWIN: whiteQ <= satInc(whiteQ);
        BLACKWIN: blackQ <= satInc(blackQ);
        DRAW:     drawQ  <= satInc(drawQ);
        default:  ;
      endcase
    end
  end

  // Minimum display time: count 0..HOLD_CYCLES-1 while in HOLD
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      holdCnt <= '0;
    else if (enterHold)                             holdCnt <= '0;
    else if (state == HOLD && holdCnt != HOLD_LAST) holdCnt <= holdCnt + 1'b1;
  end

  // Result LED blink, restarted on HOLD entry and idle outside game-over
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blinkCnt <= '0;
      blinkQ   <= 1'b0;
    end else if (enterHold || !gameOver) begin
      blinkCnt <= '0;
      blinkQ   <= 1'b0;
    end else if (blinkCnt == BLINK_LAST) begin
      blinkCnt <= '0;
      blinkQ   <= ~blinkQ;
    end else begin
      blinkCnt <= blinkCnt + 1'b1;
    end
  end

  // Informational move count; commits outside active play are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      moveCnt <= '0;
    else if (moveCommit && (state == PLAY || state == CHECKED))
      moveCnt <= moveCnt + 1'b1;
  end

  assign gameOver    = (state == HOLD) || (state == WAIT_NEW);
  assign checkLed    = (state == CHECKED);
  assign boardReset  = (state == CLEAR);
  assign resultBlink = blinkQ & gameOver;
  assign result      = resultQ;
  assign whiteScore  = whiteQ;
  assign blackScore  = blackQ;
  assign drawCount   = drawQ;

endmodule
